// File: rtl/spi_master_ctrl.sv
// SPI initiator sharing clk with the slave: shifts a 10-bit command out MSB-first
// inside an SS_n-low frame and, for read-data commands, captures the returned byte.
module spi_master_ctrl #(
  parameter int RD_GAP   = 2,
  parameter int IDLE_GAP = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [9:0] cmd_word,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SEL  = 3'd1,
    S_SEND = 3'd2,
    S_GAP  = 3'd3,
    S_RECV = 3'd4,
    S_END  = 3'd5
  } state_t;

  // Handshake: start is a level request sampled only on an edge where the FSM
  // sits in IDLE; busy reports the FSM is anywhere else, done marks frame end.
  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic [3:0] limit;
  logic       last;
  logic [9:0] shreg;
  logic [6:0] rx_shreg;
  logic [3:0] bit_idx;
  logic       is_rd;

  assign is_rd = (shreg[9:8] == 2'b11);

  always_comb begin
    limit = 4'd1;
    case (state)
      S_SEND:  limit = 4'd10;
      S_GAP:   limit = 4'(RD_GAP);
      S_RECV:  limit = 4'd8;
      S_END:   limit = 4'(IDLE_GAP);
      default: limit = 4'd1;
    endcase
  end

  assign last = (cnt == limit - 4'd1);

  // State register and datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      shreg    <= 10'd0;
      rx_shreg <= 7'd0;
      rd_data  <= 8'h00;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE || state_nxt != state) begin
        cnt <= 4'd0;
      end else begin
        cnt <= cnt + 4'd1;
      end
      if (state == S_IDLE && start) begin
        shreg <= cmd_word;
      end
      if (state == S_RECV) begin
        rx_shreg <= {rx_shreg[5:0], MISO};
        if (last) begin
          rd_data <= {rx_shreg, MISO};
        end
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_SEL;
      S_SEL:  state_nxt = S_SEND;
      S_SEND: if (last) state_nxt = is_rd ? S_GAP : S_END;
      S_GAP:  if (last) state_nxt = S_RECV;
      S_RECV: if (last) state_nxt = S_END;
      S_END:  if (last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bit_idx = 4'd9 - cnt;

  // Output logic: Moore outputs so reset forces SS_n high with no edge needed
  always_comb begin
    SS_n     = 1'b1;
    MOSI     = 1'b0;
    busy     = (state != S_IDLE);
    done     = 1'b0;
    rd_valid = 1'b0;
    case (state)
      S_SEL: begin
        SS_n = 1'b0;
        MOSI = shreg[9];
      end
      S_SEND: begin
        SS_n = 1'b0;
        MOSI = shreg[bit_idx];
      end
      S_GAP, S_RECV: SS_n = 1'b0;
      S_END: begin
        done     = (cnt == 4'd0);
        rd_valid = (cnt == 4'd0) && is_rd;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl with a behavioural RAM slave on MISO and
// a scoreboard of expected frames and read bytes.
module tb_spi_master_ctrl;

  localparam int LEN_WR = 11;
  localparam int LEN_RD = 11 + 2 + 8;
  localparam int GAP_HI = 1 + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [9:0] cmd_word = 10'd0;
  logic       busy, done, rd_valid, ss_n, mosi;
  logic [7:0] rd_data;
  logic       miso = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_q[$];
  logic [10:0] exp_mosi_q[$];
  int          exp_len_q[$];

  logic [7:0]  mem [256];
  logic [7:0]  addr = 8'h00;
  logic [7:0]  miso_byte = 8'h00;
  logic [10:0] cap = 11'd0;
  logic        extra = 1'b0;
  int          low_cnt = 0;
  int          high_cnt = 0;
  int          done_cnt = 0;
  logic        abort = 1'b0;
  logic        gap_check = 1'b0;

  spi_master_ctrl #(.RD_GAP(2), .IDLE_GAP(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .cmd_word (cmd_word),
    .busy     (busy),
    .done     (done),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .SS_n     (ss_n),
    .MOSI     (mosi),
    .MISO     (miso)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slave model and monitor: everything sampled on the falling edge.
  always @(negedge clk) begin
    logic frame_end;
    int   el;
    logic [10:0] em;
    frame_end = 1'b0;
    if (ss_n === 1'b0) begin
      if (low_cnt == 0) begin
        if (gap_check) check("idle_gap", high_cnt, GAP_HI);
        cap   = 11'd0;
        extra = 1'b0;
      end
      if (low_cnt <= 10) cap = {cap[9:0], mosi};
      else if (mosi !== 1'b0) extra = 1'b1;
      if (low_cnt == 11) miso_byte = (cap[9:8] == 2'b11) ? mem[addr] : 8'h00;
      miso = (low_cnt >= 13 && low_cnt <= 20) ? miso_byte[20 - low_cnt] : 1'b0;
      low_cnt++;
      high_cnt = 0;
    end else begin
      miso = 1'b0;
      if (low_cnt != 0) begin
        if (abort) begin
          abort = 1'b0;
        end else if (exp_len_q.size() == 0) begin
          check("unexpected_frame_len", low_cnt, 0);
        end else begin
          frame_end = 1'b1;
          el = exp_len_q.pop_front();
          em = exp_mosi_q.pop_front();
          check("frame_len", low_cnt, el);
          check("mosi_bits", cap, em);
          check("mosi_tail_zero", extra, 0);
          check("done_at_end", done, 1);
          check("rd_valid_at_end", rd_valid, el == LEN_RD);
          case (cap[9:8])
            2'b00, 2'b10: addr = cap[7:0];
            2'b01:        mem[addr] = cap[7:0];
            default: ;
          endcase
        end
        low_cnt = 0;
      end
      high_cnt++;
    end
    if (done === 1'b1) begin
      done_cnt++;
      if (!frame_end) check("done_spurious", done, 0);
    end
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) check("rd_valid_spurious", rd_valid, 0);
      else check("rd_data", rd_data, exp_q.pop_front());
    end
  end

  task automatic push_exp(input logic [9:0] cmd, input logic [7:0] exp_rd);
    exp_len_q.push_back((cmd[9:8] == 2'b11) ? LEN_RD : LEN_WR);
    exp_mosi_q.push_back({cmd[9], cmd});
    if (cmd[9:8] == 2'b11) exp_q.push_back(exp_rd);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy !== 1'b0) check("wait_idle_timeout", busy, 0);
  endtask

  task automatic wait_busy();
    int n = 0;
    while (busy !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy !== 1'b1) check("wait_busy_timeout", busy, 1);
  endtask

  task automatic frame(input logic [9:0] cmd, input logic [7:0] exp_rd);
    wait_idle();
    cmd_word = cmd;
    start    = 1'b1;
    push_exp(cmd, exp_rd);
    @(posedge clk); #1;
    start    = 1'b0;
    cmd_word = 10'($urandom_range(0, 1023));
    check("accept_busy", busy, 1);
    wait_idle();
  endtask

  initial begin
    int d0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // 1: reset held with start high
    start    = 1'b1;
    cmd_word = 10'h3FF;
    repeat (4) @(posedge clk);
    #1;
    check("rst_ss_n", ss_n, 1);
    check("rst_mosi", mosi, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_done", done, 0);
    check("rst_rd_valid", rd_valid, 0);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_ss_n", ss_n, 1);
    check("post_rst_busy", busy, 0);

    // 2: write address
    d0 = done_cnt;
    frame(10'h0A5, 8'h00);
    check("t2_done_once", done_cnt - d0, 1);
    check("t2_rd_data_kept", rd_data, 8'h00);

    // 3: loopback through the RAM model
    frame(10'h012, 8'h00);
    frame(10'h13C, 8'h00);
    frame(10'h212, 8'h00);
    frame(10'h300, 8'h3C);
    check("t3_rd_data", rd_data, 8'h3C);

    // 4: two reads with preloaded RAM bytes
    mem[8'h40] = 8'hA6;
    mem[8'h41] = 8'h5B;
    frame(10'h240, 8'h00);
    frame(10'h300, 8'hA6);
    check("t4_rd_a6", rd_data, 8'hA6);
    frame(10'h241, 8'h00);
    frame(10'h300, 8'h5B);
    check("t4_rd_5b", rd_data, 8'h5B);

    // 5: start held high, cmd_word changed mid-frame
    wait_idle();
    cmd_word = 10'h0A5;
    start    = 1'b1;
    push_exp(10'h0A5, 8'h00);
    wait_busy();
    repeat (5) @(posedge clk);
    #1;
    gap_check = 1'b1;
    cmd_word  = 10'h15A;
    push_exp(10'h15A, 8'h00);
    wait_idle();
    wait_busy();
    repeat (5) @(posedge clk);
    #1;
    cmd_word = 10'h2C3;
    push_exp(10'h2C3, 8'h00);
    wait_idle();
    wait_busy();
    start = 1'b0;
    wait_idle();
    gap_check = 1'b0;
    check("t5_rd_data_kept", rd_data, 8'h5B);

    // 6: reset during RECV cycle 4
    wait_idle();
    cmd_word = 10'h300;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("t6_accept", busy, 1);
    repeat (16) @(posedge clk);
    #1;
    check("t6_pre_ss_n", ss_n, 0);
    d0    = done_cnt;
    abort = 1'b1;
    rst_n = 1'b0;
    #1;
    check("t6_ss_n_now", ss_n, 1);
    check("t6_busy_now", busy, 0);
    check("t6_mosi_now", mosi, 0);
    check("t6_rd_data", rd_data, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t6_no_done", done_cnt - d0, 0);
    check("t6_rd_data_hold", rd_data, 8'h00);
    frame(10'h077, 8'h00);
    frame(10'h1E1, 8'h00);
    frame(10'h277, 8'h00);
    frame(10'h300, 8'hE1);
    check("t6_clean_rd", rd_data, 8'hE1);

    repeat (4) @(posedge clk);
    #1;
    check("exp_q_empty", exp_q.size(), 0);
    check("frame_q_empty", exp_len_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
